// File: rtl/uart_tx_serializer_if.sv
// FIFO read-side handshake between the TX FIFO (first-word-fall-through) and the
// serializer. The serializer is the master: it pops words from the FIFO.
interface uart_tx_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_empty;
  logic                  fifo_rd;

  modport master (
    input  fifo_data,
    input  fifo_empty,
    output fifo_rd
  );

  modport slave (
    output fifo_data,
    output fifo_empty,
    input  fifo_rd
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops one FIFO word per frame and shifts out
// start, 5-8 data bits LSB first, optional parity and 1-2 stop bits on txd.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int OS_RATE    = 16
) (
  input  logic                        wclk,
  input  logic                        rst_n,
  uart_tx_serializer_if.master        fifo,
  input  logic                        baud_tick,
  input  logic                        tx_en,
  input  logic [1:0]                  data_len,
  input  logic                        parity_en,
  input  logic                        parity_odd,
  input  logic                        stop2,
  output logic                        txd,
  output logic                        tx_busy,
  output logic                        tx_done
);

  localparam int CNT_W = (OS_RATE > 1) ? $clog2(OS_RATE) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OS_RATE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Parity over the data bits actually sent; bits above the frame length are ignored.
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data,
                                       input logic [1:0]            len,
                                       input logic                  odd);
    logic p;
    p = odd;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i < (int'(len) + 5)) p = p ^ data[i];
      else                     p = p;
    end
    return p;
  endfunction

  state_t                state_r, next_state_s;
  logic [CNT_W-1:0]      tick_cnt_r;
  logic [2:0]            bit_cnt_r;
  logic [DATA_WIDTH-1:0] shift_r, shift_next_s;
  logic [1:0]            len_r;
  logic                  par_en_r;
  logic                  stop2_r;
  logic                  parity_r;
  logic                  txd_r, txd_next_s;
  logic                  tx_done_r;
  logic                  fifo_rd_s;
  logic                  bit_end_s;
  logic [2:0]            bit_last_s;
  logic [2:0]            stop_last_s;

  assign fifo_rd_s   = rst_n & tx_en & ~fifo.fifo_empty & (state_r == IDLE);
  assign fifo.fifo_rd = fifo_rd_s;
  assign bit_end_s   = baud_tick & (tick_cnt_r == TICK_LAST);
  assign bit_last_s  = {1'b0, len_r} + 3'd4;
  assign stop_last_s = stop2_r ? 3'd1 : 3'd0;

  assign txd     = txd_r;
  assign tx_busy = (state_r != IDLE);
  assign tx_done = tx_done_r;

  // Next-state, next shift value and next line level.
  always_comb begin
    next_state_s = state_r;
    shift_next_s = shift_r;
    txd_next_s   = 1'b1;
    case (state_r)
      IDLE: begin
        if (fifo_rd_s) next_state_s = START;
        else           next_state_s = IDLE;
      end
      START: begin
        if (bit_end_s) next_state_s = DATA;
        else           next_state_s = START;
      end
      DATA: begin
        if (bit_end_s && (bit_cnt_r == bit_last_s)) begin
          next_state_s = par_en_r ? PARITY : STOP;
        end else if (bit_end_s) begin
          shift_next_s = {1'b0, shift_r[DATA_WIDTH-1:1]};
        end else begin
          next_state_s = DATA;
        end
      end
      PARITY: begin
        if (bit_end_s) next_state_s = STOP;
        else           next_state_s = PARITY;
      end
      STOP: begin
        if (bit_end_s && (bit_cnt_r == stop_last_s)) next_state_s = IDLE;
        else                                          next_state_s = STOP;
      end
      default: next_state_s = IDLE;
    endcase

    // txd follows the state being entered so both change on the same edge.
    case (next_state_s)
      START:   txd_next_s = 1'b0;
      DATA:    txd_next_s = shift_next_s[0];
      PARITY:  txd_next_s = parity_r;
      default: txd_next_s = 1'b1;
    endcase
  end

  // State, line and done-pulse registers.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      txd_r     <= 1'b1;
      tx_done_r <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      txd_r     <= txd_next_s;
      tx_done_r <= (state_r == STOP) && (next_state_s == IDLE);
    end
  end

  // Word capture, shadow configuration and bit/tick counters.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r    <= '0;
      len_r      <= 2'b00;
      par_en_r   <= 1'b0;
      stop2_r    <= 1'b0;
      parity_r   <= 1'b0;
      tick_cnt_r <= '0;
      bit_cnt_r  <= 3'd0;
    end else if (fifo_rd_s) begin
      shift_r    <= fifo.fifo_data;
      len_r      <= data_len;
      par_en_r   <= parity_en;
      stop2_r    <= stop2;
      parity_r   <= calc_parity(fifo.fifo_data, data_len, parity_odd);
      tick_cnt_r <= '0;
      bit_cnt_r  <= 3'd0;
    end else begin
      shift_r <= shift_next_s;
      if (baud_tick && (state_r != IDLE)) begin
        tick_cnt_r <= (tick_cnt_r == TICK_LAST) ? '0 : tick_cnt_r + CNT_W'(1);
      end else begin
        tick_cnt_r <= tick_cnt_r;
      end
      // bit_cnt counts data bits in DATA and stop bits in STOP.
      if (next_state_s != state_r) begin
        bit_cnt_r <= 3'd0;
      end else if (bit_end_s && ((state_r == DATA) || (state_r == STOP))) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
    end
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Transmit serializer of the UART IP. It sits directly downstream of the transmit FIFO, which is first-word-fall-through: the head word is valid on `fifo_data` whenever `fifo_empty` is low. The block pops one word per frame and drives the serial `txd` line: start bit, 5–8 data bits LSB first, optional parity, then 1 or 2 stop bits. Bit timing comes from an oversampling `baud_tick` enable generated by the baud-rate generator.

## Interface
- `DATA_WIDTH`, 8: FIFO word width; maximum frame data length.
- `OS_RATE`, 16: `baud_tick` pulses per serial bit; counter width is clog2(OS_RATE).
- `wclk`  in  1  block clock; same clock as the TX FIFO write/read side.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `fifo_data`  in  DATA_WIDTH  FIFO head word, valid while `fifo_empty`=0.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd`  out  1  FIFO pop strobe, combinational, one cycle per frame.
- `baud_tick`  in  1  one-`wclk` enable pulse at OS_RATE × baud.
- `tx_en`  in  1  transmitter enable.
- `data_len`  in  2  data bits: 00=5, 01=6, 10=7, 11=8.
- `parity_en`  in  1  insert parity bit.
- `parity_odd`  in  1  1=odd, 0=even parity.
- `stop2`  in  1  1=two stop bits, 0=one.
- `txd`  out  1  serial output, registered, idle high.
- `tx_busy`  out  1  frame in progress (state≠IDLE).
- `tx_done`  out  1  registered one-cycle pulse at frame completion.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: `fifo_rd` = rst_n & tx_en & ~fifo_empty & (state==IDLE). In that cycle, the block captures `fifo_data` into the shift register and latches `data_len`, `parity_en`, `parity_odd` and `stop2` into shadow registers. It also clears the tick counter and bit counter. The next state is START.
- A frame always uses the shadow configuration. Changing the configuration inputs mid-frame has no effect until the next load.
- Deasserting `tx_en` mid-frame lets the current frame complete. No further pop occurs while `tx_en`=0.
- Tick counter: increments on each `baud_tick`. On the tick where the counter equals OS_RATE-1, the current bit ends, the counter wraps to 0 and the FSM advances.
- START→DATA; txd=0.
- DATA: txd = shift[0], with right shift at each bit end. After the data_len-th bit, go to PARITY if `parity_en`, else STOP.
- PARITY: txd = XOR of the transmitted data bits only (bits above data_len excluded), inverted when `parity_odd`. Then go to STOP.
- STOP: txd=1 for 1 or 2 bit times, then go to IDLE and pulse `tx_done`.
- `txd` is updated on the same edge as the state transition. `txd`=1 in IDLE and STOP.
- Reset values: state IDLE, txd=1, tx_busy=0, tx_done=0, fifo_rd=0 (gated by rst_n), shift register 0, counters 0.
- Reset asserted mid-frame: `txd` returns to 1 immediately (asynchronous reset). The frame is aborted, the popped word is lost, and no `tx_done` is issued.
- FIFO empty in IDLE: the block stays IDLE with txd=1. Pops never occur while `fifo_empty`=1, so FIFO underflow is impossible.

## Timing
- Pop to START: `fifo_rd` is high in cycle N; START and txd=0 take effect at edge N+1.
- Start-bit length: from entry until the OS_RATE-th `baud_tick` after entry. This is (OS_RATE-1, OS_RATE] tick periods, depending on tick phase.
- Every later bit lasts exactly OS_RATE `baud_tick` periods.
- Back-to-back frames: after STOP→IDLE, the next `fifo_rd` occurs in the first IDLE cycle. The line therefore stays high for exactly 1 extra `wclk` between frames.
- With `baud_tick` held at 1, a frame lasts OS_RATE × (1 + n + p + s) cycles, where n = data bits, p = parity bits, s = stop bits.
- `tx_done` is asserted in the first IDLE cycle after STOP, for exactly 1 cycle.

## Test plan
- Reset: hold rst_n=0 with tx_en=1 and fifo_empty=0 → txd=1, fifo_rd=0, tx_busy=0, tx_done=0.
- 8N1 with byte 0xA5 and baud_tick tied to 1:
  - fifo_rd is high for 1 cycle.
  - txd is 0×16, then 1,0,1,0,0,1,0,1 for 16 cycles each, then 1×16.
  - tx_done pulses at cycle 161 after the pop.
- 7E2 with 0x35 → data bits 1,0,1,0,1,1,0, parity 0, two stop bits. Repeating with 7O2 → parity 1.
- 5E1 with 0x1F (upper bits 0) → 5 data bits of 1, then parity 1. Repeating with 0xFF → identical frame (bits above data_len ignored).
- Back-to-back 0x00 then 0xFF with fifo_empty low → exactly 2 fifo_rd pulses, with exactly 1 idle-high cycle between the last stop bit and the second start bit. Changing data_len to 00 during the first frame's DATA state → first frame still has 8 data bits.
- Reset pulsed in DATA state → txd=1 asynchronously, tx_busy=0, no tx_done. With tx_en=0 and the FIFO non-empty → no fifo_rd and txd stays 1.
